// File: rtl/wb_rr_arbiter_pkg.sv
// Shared state encoding and arbitration helper for the two-master Wishbone round-robin arbiter.
package wb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_e;

  localparam int WDOG_W = 16;

  // A lone requester wins; on a tie the master that did not own the bus last time wins.
  function automatic logic [1:0] rr_pick(input logic req0, input logic req1, input logic last);
    logic [1:0] pick;
    if (req0 && req1) pick = last ? 2'b01 : 2'b10;
    else              pick = {req1, req0};
    return pick;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Slave-response watchdog: counts consecutive stalled strobe cycles and flags expiry.
// Present only when WB_ARB_TIMEOUT_EN is defined.
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_watchdog
  import wb_rr_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_active,
  input  logic i_resp,
  output logic o_expire
);

  localparam logic [WDOG_W-1:0] THRESH = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Saturates at all-ones; the threshold is always reached first for legal TIMEOUT values.
  always_comb begin
    wdog_d = wdog_q;
    if (!i_active || i_resp)              wdog_d = '0;
    else if (wdog_q != {WDOG_W{1'b1}})    wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) wdog_q <= '0;
    else          wdog_q <= wdog_d;
  end

  assign o_expire = i_active & ~i_resp & (wdog_q == THRESH);

endmodule
`endif

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter with burst passthrough.
// Define WB_ARB_TIMEOUT_EN to add the slave-response watchdog and ABORT state.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int SEL_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [DATA_W-1:0] m0_o_dat,
  input  logic [SEL_W-1:0]  m0_sel,
  input  logic              m0_4_burst,
  input  logic              m0_8_burst,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [DATA_W-1:0] m1_o_dat,
  input  logic [SEL_W-1:0]  m1_sel,
  input  logic              m1_4_burst,
  input  logic              m1_8_burst,
  output logic              m1_ack,
  output logic              m1_err,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_adr,
  output logic [DATA_W-1:0] o_wb_o_dat,
  output logic [SEL_W-1:0]  o_wb_sel,
  output logic              o_wb_4_burst,
  output logic              o_wb_8_burst,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  output logic [1:0]        o_grant,
  output logic [1:0]        o_dbg_state
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic [1:0] pick;
  logic       own1, own_cyc, own_stb, busy;
  logic       resp_ack, resp_err, abort_pulse;

  assign own1    = grant_q[1];
  assign own_cyc = own1 ? m1_cyc : m0_cyc;
  assign own_stb = own1 ? m1_stb : m0_stb;
  assign busy    = (state_q == ARB_BUSY);
  assign pick    = rr_pick(m0_cyc, m1_cyc, last_q);

`ifdef WB_ARB_TIMEOUT_EN
  logic expire, abort_q, abort_d;

  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_active (busy & own_stb),
    .i_resp   (i_wb_ack | i_wb_err),
    .o_expire (expire)
  );

  // One-cycle error to the owner on the edge that enters ABORT.
  assign abort_d     = busy & own_cyc & expire;
  assign abort_pulse = abort_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) abort_q <= 1'b0;
    else          abort_q <= abort_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 1);
  assign abort_pulse    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_cyc || m1_cyc) begin
          grant_d = pick;
          last_d  = pick[1];
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (!own_cyc) begin
          state_d = ARB_IDLE;
          grant_d = 2'b00;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (expire) begin
          state_d = ARB_ABORT;
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ARB_ABORT: begin
        if (!own_cyc) begin
          state_d = ARB_IDLE;
          grant_d = 2'b00;
        end
      end
`endif
      default: begin
        state_d = ARB_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Owner's signals pass straight through; cyc/stb only while BUSY so ABORT drops the bus.
  always_comb begin
    o_wb_cyc     = 1'b0;
    o_wb_stb     = 1'b0;
    o_wb_we      = 1'b0;
    o_wb_adr     = '0;
    o_wb_o_dat   = '0;
    o_wb_sel     = '0;
    o_wb_4_burst = 1'b0;
    o_wb_8_burst = 1'b0;
    if (state_q != ARB_IDLE) begin
      o_wb_cyc     = busy & own_cyc;
      o_wb_stb     = busy & own_stb;
      o_wb_we      = own1 ? m1_we      : m0_we;
      o_wb_adr     = own1 ? m1_adr     : m0_adr;
      o_wb_o_dat   = own1 ? m1_o_dat   : m0_o_dat;
      o_wb_sel     = own1 ? m1_sel     : m0_sel;
      o_wb_4_burst = own1 ? m1_4_burst : m0_4_burst;
      o_wb_8_burst = own1 ? m1_8_burst : m0_8_burst;
    end
  end

  assign resp_ack = busy & i_wb_ack;
  assign resp_err = (busy & i_wb_err) | abort_pulse;

  assign m0_ack = grant_q[0] & resp_ack;
  assign m0_err = grant_q[0] & resp_err;
  assign m1_ack = grant_q[1] & resp_ack;
  assign m1_err = grant_q[1] & resp_err;

  assign o_grant     = grant_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios plus randomized traffic against a bus-ownership model.
// Define WB_ARB_TIMEOUT_EN to include the watchdog scenarios.
module tb_wb_rr_arbiter;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 16;
  localparam int SEL_W      = 2;
  localparam int TB_TIMEOUT = 4;
  localparam int VW         = 2 + 2 + 9 + SEL_W + ADDR_W + DATA_W;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk, rst_n;
  logic              m0_cyc, m0_stb, m0_we, m0_4_burst, m0_8_burst, m0_ack, m0_err;
  logic [ADDR_W-1:0] m0_adr;
  logic [DATA_W-1:0] m0_o_dat;
  logic [SEL_W-1:0]  m0_sel;
  logic              m1_cyc, m1_stb, m1_we, m1_4_burst, m1_8_burst, m1_ack, m1_err;
  logic [ADDR_W-1:0] m1_adr;
  logic [DATA_W-1:0] m1_o_dat;
  logic [SEL_W-1:0]  m1_sel;
  logic              o_wb_cyc, o_wb_stb, o_wb_we, o_wb_4_burst, o_wb_8_burst;
  logic [ADDR_W-1:0] o_wb_adr;
  logic [DATA_W-1:0] o_wb_o_dat;
  logic [SEL_W-1:0]  o_wb_sel;
  logic              i_wb_ack, i_wb_err;
  logic [1:0]        o_grant, o_dbg_state;

  wb_rr_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_o_dat(m0_o_dat),
    .m0_sel(m0_sel), .m0_4_burst(m0_4_burst), .m0_8_burst(m0_8_burst),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_o_dat(m1_o_dat),
    .m1_sel(m1_sel), .m1_4_burst(m1_4_burst), .m1_8_burst(m1_8_burst),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_adr(o_wb_adr),
    .o_wb_o_dat(o_wb_o_dat), .o_wb_sel(o_wb_sel),
    .o_wb_4_burst(o_wb_4_burst), .o_wb_8_burst(o_wb_8_burst),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .o_grant(o_grant), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- bus-ownership model ----------------
  // owner: -1 when nobody holds the bus; stall counts consecutive unanswered strobes.
  int mdl_owner = -1;
  int mdl_last  = 1;
  bit mdl_abort = 1'b0;
  bit mdl_abort_new = 1'b0;
  int mdl_stall = 0;
  logic [VW-1:0] exp_q[$];

  task automatic mdl_step();
    logic oc, os;
    mdl_abort_new = 1'b0;
    if (mdl_owner < 0) begin
      if (m0_cyc && m1_cyc) mdl_owner = 1 - mdl_last;
      else if (m0_cyc)      mdl_owner = 0;
      else if (m1_cyc)      mdl_owner = 1;
      if (mdl_owner >= 0) begin
        mdl_last  = mdl_owner;
        mdl_stall = 0;
      end
    end else begin
      oc = (mdl_owner == 1) ? m1_cyc : m0_cyc;
      os = (mdl_owner == 1) ? m1_stb : m0_stb;
      if (!oc) begin
        mdl_owner = -1;
        mdl_abort = 1'b0;
        mdl_stall = 0;
      end else if (TO_EN && !mdl_abort) begin
        if (os && !i_wb_ack && !i_wb_err) mdl_stall++;
        else                              mdl_stall = 0;
        if (mdl_stall == TB_TIMEOUT) begin
          mdl_abort     = 1'b1;
          mdl_abort_new = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [VW-1:0] mdl_vec();
    logic [1:0] st, gr;
    logic cyc, stb, we, b4, b8, a0, e0, a1, e1, ackr, errr;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
    {st, gr, cyc, stb, we, b4, b8, a0, e0, a1, e1, ackr, errr} = '0;
    sel = '0; adr = '0; dat = '0;
    if (rst_n && mdl_owner >= 0) begin
      gr = (mdl_owner == 1) ? 2'b10 : 2'b01;
      st = mdl_abort ? 2'd2 : 2'd1;
      if (mdl_owner == 1) begin
        we = m1_we; adr = m1_adr; dat = m1_o_dat; sel = m1_sel; b4 = m1_4_burst; b8 = m1_8_burst;
        cyc = m1_cyc; stb = m1_stb;
      end else begin
        we = m0_we; adr = m0_adr; dat = m0_o_dat; sel = m0_sel; b4 = m0_4_burst; b8 = m0_8_burst;
        cyc = m0_cyc; stb = m0_stb;
      end
      if (mdl_abort) begin
        cyc = 1'b0; stb = 1'b0; errr = mdl_abort_new;
      end else begin
        ackr = i_wb_ack; errr = i_wb_err;
      end
      if (mdl_owner == 1) begin a1 = ackr; e1 = errr; end
      else                begin a0 = ackr; e0 = errr; end
    end
    return {st, gr, cyc, stb, we, b4, b8, a0, e0, a1, e1, sel, adr, dat};
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mdl_owner = -1; mdl_last = 1; mdl_abort = 1'b0; mdl_abort_new = 1'b0; mdl_stall = 0;
      end else begin
        mdl_step();
      end
    end
  end

  // ---------------- scoreboard: every cycle, on the falling edge ----------------
  initial begin
    logic [VW-1:0] act, exp;
    forever begin
      @(negedge clk);
      exp_q.push_back(mdl_vec());
      act = {o_dbg_state, o_grant, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_4_burst, o_wb_8_burst,
             m0_ack, m0_err, m1_ack, m1_err, o_wb_sel, o_wb_adr, o_wb_o_dat};
      exp = exp_q.pop_front();
      check("cycle_outputs", 64'(act), 64'(exp));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {m0_cyc, m0_stb, m0_we, m0_4_burst, m0_8_burst} = '0;
    {m1_cyc, m1_stb, m1_we, m1_4_burst, m1_8_burst} = '0;
    m0_adr = '0; m0_o_dat = '0; m0_sel = '0;
    m1_adr = '0; m1_o_dat = '0; m1_sel = '0;
    i_wb_ack = 1'b0; i_wb_err = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic rand_inputs();
    if (!m0_cyc) m0_cyc = ($urandom_range(0, 2) == 0);
    else if ($urandom_range(0, 7) == 0) m0_cyc = 1'b0;
    m0_stb = m0_cyc && ($urandom_range(0, 3) != 0);
    m0_we = 1'($urandom); m0_adr = ADDR_W'($urandom); m0_o_dat = DATA_W'($urandom);
    m0_sel = SEL_W'($urandom);
    m0_4_burst = ($urandom_range(0, 3) == 0); m0_8_burst = ($urandom_range(0, 3) == 0);
    if (!m1_cyc) m1_cyc = ($urandom_range(0, 2) == 0);
    else if ($urandom_range(0, 7) == 0) m1_cyc = 1'b0;
    m1_stb = m1_cyc && ($urandom_range(0, 3) != 0);
    m1_we = 1'($urandom); m1_adr = ADDR_W'($urandom); m1_o_dat = DATA_W'($urandom);
    m1_sel = SEL_W'($urandom);
    m1_4_burst = ($urandom_range(0, 3) == 0); m1_8_burst = ($urandom_range(0, 3) == 0);
    i_wb_ack = ($urandom_range(0, 2) == 0);
    i_wb_err = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got no finish expected finish at %0t", $time);
    $fatal(1, "simulation time limit expired");
  end

  // ---------------- directed scenarios, then random traffic ----------------
  initial begin
    int acks0, acks1, errs0, bad_beats;
    clear_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_grant", 64'(o_grant), 64'(2'b00));
    check("reset_cyc", 64'(o_wb_cyc), 64'(0));
    check("reset_state", 64'(o_dbg_state), 64'(0));
    #2 rst_n = 1'b1;
    tick();

    // single request: ack on the 3rd granted cycle, owner drops cyc together with that ack
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 24'h001234; m0_o_dat = 16'hbeef; m0_sel = 2'b11;
    @(negedge clk);
    check("single_pre_cyc", 64'(o_wb_cyc), 64'(0));
    tick();
    acks0 = 0; acks1 = 0;
    for (int c = 1; c <= 3; c++) begin
      i_wb_ack = (c == 3);
      if (c == 3) begin m0_cyc = 0; m0_stb = 0; end
      @(negedge clk);
      if (c == 1) begin
        check("single_cyc", 64'(o_wb_cyc), 64'(1));
        check("single_grant", 64'(o_grant), 64'(2'b01));
        check("single_adr", 64'(o_wb_adr), 64'(24'h001234));
      end
      acks0 += int'(m0_ack);
      acks1 += int'(m1_ack);
      tick();
    end
    i_wb_ack = 0;
    @(negedge clk);
    check("single_release", 64'(o_grant), 64'(2'b00));
    check("single_m0_acks", 64'(acks0), 64'(1));
    check("single_m1_acks", 64'(acks1), 64'(0));

    // tie right after reset: m0 first, one idle gap, then m1; the next tie goes back to m0
    clear_inputs();
    do_reset();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m1_adr = 24'h00abcd;
    tick();
    @(negedge clk);
    check("tie_first", 64'(o_grant), 64'(2'b01));
    check("model_tie_first", 64'(mdl_owner), 64'(0));
    m0_cyc = 0; m0_stb = 0;
    tick();
    @(negedge clk);
    check("tie_gap", 64'(o_grant), 64'(2'b00));
    tick();
    @(negedge clk);
    check("tie_second", 64'(o_grant), 64'(2'b10));
    check("tie_second_adr", 64'(o_wb_adr), 64'(24'h00abcd));
    m1_cyc = 0; m1_stb = 0;
    tick();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick();
    @(negedge clk);
    check("tie_third", 64'(o_grant), 64'(2'b01));
    clear_inputs();
    tick(); tick();

    // 8-beat burst from m1 while m0 keeps requesting
    m1_cyc = 1; m1_stb = 1; m1_8_burst = 1;
    tick();
    m0_cyc = 1; m0_stb = 1;
    bad_beats = 0; acks1 = 0;
    for (int b = 0; b < 8; b++) begin
      i_wb_ack = 1;
      @(negedge clk);
      if (o_grant != 2'b10 || !o_wb_8_burst || m0_ack) bad_beats++;
      acks1 += int'(m1_ack);
      tick();
    end
    check("burst_beats_held", 64'(bad_beats), 64'(0));
    check("burst_m1_acks", 64'(acks1), 64'(8));
    i_wb_ack = 0; m1_cyc = 0; m1_stb = 0; m1_8_burst = 0;
    tick();
    @(negedge clk);
    check("burst_gap", 64'(o_grant), 64'(2'b00));
    tick();
    @(negedge clk);
    check("burst_m0_after", 64'(o_grant), 64'(2'b01));
    clear_inputs();
    tick(); tick();

    // ack arriving on the threshold cycle (4th stalled strobe) keeps the cycle alive
    m0_cyc = 1; m0_stb = 1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      i_wb_ack = (c == 4);
      @(negedge clk);
      if (c == 4) begin
        check("bound_ack", 64'(m0_ack), 64'(1));
        check("bound_err", 64'(m0_err), 64'(0));
      end
      tick();
    end
    i_wb_ack = 0;
    @(negedge clk);
    check("bound_continue", 64'(o_wb_cyc), 64'(1));
    check("bound_state", 64'(o_dbg_state), 64'(1));
    clear_inputs();
    tick(); tick();

`ifdef WB_ARB_TIMEOUT_EN
    // slave never answers: abort after 4 stalled cycles, one err pulse, hold until cyc drops
    m0_cyc = 1; m0_stb = 1;
    tick();
    errs0 = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      errs0 += int'(m0_err);
      tick();
    end
    check("to_no_early_err", 64'(errs0), 64'(0));
    @(negedge clk);
    check("to_err", 64'(m0_err), 64'(1));
    check("to_cyc", 64'(o_wb_cyc), 64'(0));
    check("to_state", 64'(o_dbg_state), 64'(2));
    tick();
    @(negedge clk);
    check("to_err_once", 64'(m0_err), 64'(0));
    check("to_hold", 64'(o_dbg_state), 64'(2));
    m0_cyc = 0; m0_stb = 0;
    tick();
    @(negedge clk);
    check("to_idle", 64'(o_dbg_state), 64'(0));
`else
    // without the watchdog a stalled cycle simply persists
    m0_cyc = 1; m0_stb = 1;
    tick();
    errs0 = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      errs0 += int'(m0_err);
      tick();
    end
    check("stall_no_err", 64'(errs0), 64'(0));
    check("stall_busy", 64'(o_dbg_state), 64'(1));
    check("stall_cyc", 64'(o_wb_cyc), 64'(1));
`endif
    clear_inputs();
    tick(); tick();

    // reset asserted during beat 3 of a burst
    m0_cyc = 1; m0_stb = 1; m0_4_burst = 1; m0_adr = 24'h00beef;
    tick();
    for (int b = 1; b <= 3; b++) begin
      i_wb_ack = 1;
      if (b == 3) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_grant", 64'(o_grant), 64'(2'b00));
        check("rst_cyc", 64'(o_wb_cyc), 64'(0));
        check("rst_ack", 64'(m0_ack), 64'(0));
        check("rst_adr", 64'(o_wb_adr), 64'(0));
        check("rst_burst", 64'(o_wb_4_burst), 64'(0));
      end else begin
        @(negedge clk);
        tick();
      end
    end
    clear_inputs();
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick();
    @(negedge clk);
    check("rst_tie", 64'(o_grant), 64'(2'b01));
    clear_inputs();
    tick(); tick();

    // randomized traffic, checked every cycle by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      tick();
    end
    clear_inputs();
    tick(); tick();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
